// File: rtl/icache_direct_if.sv
// Refill bus between icache_direct (master) and instruction memory (slave).
// One word per mem_req/mem_ack handshake; mem_data is valid in the ack cycle.
interface icache_direct_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;

   modport master (output mem_req, mem_addr, input mem_ack, mem_data);
   modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with whole-line refill over icache_direct_if.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache_direct #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         addr,
   input  logic                flush,
   output logic [31:0]         instr,
   output logic                pc_stall,
   icache_direct_if.master     bus,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count
);

   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TW = 32 - OB - IB - 2;
   localparam logic [31:0]   NOP      = 32'h0000_0013;
   localparam logic [OB-1:0] CNT_LAST = OB'(WORDS - 1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t           state;
   logic [LINES-1:0] valid;
   logic [OB-1:0]    cnt;
   logic             flush_pend;
   logic             mem_req_q;
   logic [31:0]      mem_addr_q;

   logic [TW-1:0]    tag_mem  [LINES];
   logic [31:0]      data_mem [LINES][WORDS];

   logic [IB-1:0]    idx;
   logic [OB-1:0]    off;
   logic [TW-1:0]    tag;
   logic             lookup_hit;
   logic [IB-1:0]    fill_idx;
   logic [TW-1:0]    fill_tag;
   logic             fill_last;
   logic             unused_addr_bits;

   assign idx  = addr[OB+IB+1:OB+2];
   assign off  = addr[OB+1:2];
   assign tag  = addr[31:OB+IB+2];
   assign unused_addr_bits = ^addr[1:0];

   // The line being refilled is addressed by the latched miss address, never by addr.
   assign fill_idx  = mem_addr_q[OB+IB+1:OB+2];
   assign fill_tag  = mem_addr_q[31:OB+IB+2];
   assign fill_last = (state == REFILL) && bus.mem_ack && (cnt == CNT_LAST);

   assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      instr    = NOP;
      pc_stall = 1'b1;
      if (state == IDLE && lookup_hit) begin
         instr    = data_mem[idx][off];
         pc_stall = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         valid      <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!lookup_hit) begin
                  valid[idx] <= 1'b0;
                  mem_addr_q <= {addr[31:OB+2], {(OB+2){1'b0}}};
                  cnt        <= '0;
                  mem_req_q  <= 1'b1;
                  state      <= REFILL;
               end
               if (flush) valid <= '0;
            end
            REFILL: begin
               if (flush) begin
                  valid      <= '0;
                  flush_pend <= 1'b1;
               end
               if (bus.mem_ack) begin
                  cnt        <= cnt + OB'(1);
                  mem_addr_q <= mem_addr_q + 32'd4;
               end
               if (fill_last) begin
                  // A flush seen at any point of this refill leaves the new line invalid.
                  if (!flush_pend && !flush) valid[fill_idx] <= 1'b1;
                  flush_pend <= 1'b0;
                  mem_req_q  <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: data and tag arrays carry no reset; valid bits alone decide whether their contents count.
   always_ff @(posedge clk) begin
      if (state == REFILL && bus.mem_ack) begin
         data_mem[fill_idx][cnt] <= bus.mem_data;
         if (cnt == CNT_LAST) tag_mem[fill_idx] <= fill_tag;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (state == IDLE) begin
         if (lookup_hit) hit_q  <= hit_q + 32'd1;
         else            miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: expected refill addresses are queued per fetch and
// popped as the cache issues acked requests; hit data comes from a memory model function.
module tb_icache_direct;

   localparam int          WORDS = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        flush;
   logic [31:0] instr;
   logic        pc_stall;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   icache_direct_if bus ();

   icache_direct #(.LINES(16), .WORDS(WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .flush      (flush),
      .instr      (instr),
      .pc_stall   (pc_stall),
      .bus        (bus.master),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int          n_vec      = 0;
   int          n_bad      = 0;
   int          wait_cnt   = 0;
   int          exp_hits   = 0;
   int          exp_misses = 0;
   logic [31:0] exp_q [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory side: ack after `waits` idle request cycles per word, data valid with the ack.
   task automatic drive_mem(input int waits);
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      if (bus.mem_req === 1'b1) begin
         if (wait_cnt >= waits) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = mem_word(bus.mem_addr);
            wait_cnt     = 0;
         end else begin
            wait_cnt++;
         end
      end
   endtask

   task automatic check_req();
      if (bus.mem_req === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_req", {31'd0, bus.mem_req}, 32'd0);
         else begin
            check("mem_addr", bus.mem_addr, exp_q[0]);
            if (bus.mem_ack) void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic check_perf();
`ifdef ICACHE_PERF_EN
      check("hit_count", hit_count, 32'(exp_hits));
      check("miss_count", miss_count, 32'(exp_misses));
`else
      check("hit_count_tied", hit_count, 32'd0);
      check("miss_count_tied", miss_count, 32'd0);
`endif
   endtask

   // Called at a negedge; returns at the negedge after the hit cycle.
   // flush_word >= 0 pulses flush while that refill word is presented; -2 pulses it on cycle 0.
   task automatic fetch(input logic [31:0] a, input int refills, input int waits, input int flush_word);
      int stalls  = 0;
      int acks    = 0;
      int cyc     = 0;
      bit flushed = 1'b0;
      bit done    = 1'b0;
      for (int i = 0; i < refills * WORDS; i++)
         exp_q.push_back({a[31:4], 4'b0000} + 32'(4 * (i % WORDS)));
      exp_misses += refills;
      while (!done && cyc < 300) begin
         addr  = a;
         flush = (flush_word == -2 && cyc == 0) ||
                 (flush_word >= 0 && !flushed && bus.mem_req === 1'b1 && acks == flush_word);
         if (flush && flush_word >= 0) flushed = 1'b1;
         drive_mem(waits);
         if (bus.mem_ack) acks++;
         #1;
         check_req();
         if (pc_stall) begin
            stalls++;
            check("stall_nop", instr, NOP);
         end else begin
            done = 1'b1;
            exp_hits++;
            check("hit_instr", instr, mem_word(a));
            check("hit_noreq", {31'd0, bus.mem_req}, 32'd0);
         end
         cyc++;
         @(negedge clk);
      end
      flush = 1'b0;
      check("fetch_done", {31'd0, done}, 32'd1);
      check("stall_cycles", 32'(stalls), 32'(refills * (WORDS + 1 + WORDS * waits)));
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      rst          = 1'b0;
      addr         = 32'h0000_0100;
      flush        = 1'b0;
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", {31'd0, pc_stall}, 32'd1);
      check("rst_instr", instr, NOP);
      check("rst_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check_perf();
      @(negedge clk);
      rst = 1'b1;

      // Cold miss, then hits across the filled line, then conflict eviction on index 0.
      fetch(32'h0000_0100, 1, 0, -1);
      fetch(32'h0000_0104, 0, 0, -1);
      fetch(32'h0000_0108, 0, 0, -1);
      fetch(32'h0000_010C, 0, 0, -1);
      fetch(32'h0000_0200, 1, 0, -1);
      fetch(32'h0000_0100, 1, 0, -1);
      check_perf();

      // Three wait states per word: 1 + 4*4 = 17 stall cycles.
      fetch(32'h0000_0500, 1, 3, -1);
      fetch(32'h0000_0504, 0, 0, -1);

      // Flush on the second refill word: line stays invalid, same address refills again,
      // and the flush also dropped the 0x500 line.
      fetch(32'h0000_0610, 2, 0, 1);
      fetch(32'h0000_0504, 1, 0, -1);
      fetch(32'h0000_061C, 0, 0, -1);

      // Flush in IDLE alongside a hit: the hit is served, the next lookup misses.
      fetch(32'h0000_0508, 0, 0, -2);
      fetch(32'h0000_050C, 1, 0, -1);
      check_perf();

      // Asynchronous reset in the middle of a refill.
      addr = 32'h0000_0320;
      for (int i = 0; i < 3; i++) begin
         drive_mem(0);
         #1;
         @(negedge clk);
      end
      #2;
      rst         = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      check("arst_req", {31'd0, bus.mem_req}, 32'd0);
      check("arst_stall", {31'd0, pc_stall}, 32'd1);
      check("arst_instr", instr, NOP);
      exp_hits   = 0;
      exp_misses = 0;
      wait_cnt   = 0;
      check_perf();
      @(negedge clk);
      rst = 1'b1;
      fetch(32'h0000_0100, 1, 0, -1);
      fetch(32'h0000_0320, 1, 0, -1);
      fetch(32'h0000_010C, 0, 0, -1);
      check_perf();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the fetch stage's program counter and the external instruction memory. It looks up the fetch address combinationally and returns the instruction word on a hit. On a miss it raises `pc_stall`, emits a NOP bubble, and refills the whole line from memory through a req/ack word handshake. A `flush` input invalidates all lines for `fence.i`.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `addr` input 32: fetch address from the PC; bits [1:0] are ignored.
- `flush` input 1: one-cycle pulse that invalidates all lines.
- `instr` output 32: instruction word; valid when `pc_stall` is 0.
- `pc_stall` output 1: holds the PC while a lookup misses or a refill is in progress.
- `mem_req` output 1: refill word request.
- `mem_addr` output 32: word-aligned refill address.
- `mem_ack` input 1: memory accepts the request; `mem_data` is valid in the same cycle.
- `mem_data` input 32: refill data.
- `hit_count` output 32: lookup hit counter (see Configuration).
- `miss_count` output 32: lookup miss counter (see Configuration).

## Operation
- **Address split:**
  - `OB = log2(WORDS)`, `IB = log2(LINES)`.
  - Word offset is `addr[OB+1:2]`.
  - Index is `addr[OB+IB+1:OB+2]`.
  - Tag is `addr[31:OB+IB+2]`. With the defaults this gives offset [3:2], index [7:4], tag [31:8].
- **Storage:** per line, a valid bit, a tag and `WORDS` data words, all held in registers. Reads are asynchronous.
- **State `IDLE`:**
  - Hit means `valid[idx]` is set and `tag[idx] == addr tag`.
  - On a hit: `instr` = stored word and `pc_stall` = 0.
  - On a miss: `instr` = 0x00000013 (NOP) and `pc_stall` = 1. Latch `miss_base = {addr[31:OB+2], OB+2 zero bits}`, clear the word counter and go to `REFILL`.
- **State `REFILL`:**
  - `mem_req` = 1 and `mem_addr` = `miss_base + 4*cnt`.
  - When `mem_ack` is high, write `mem_data` into word `cnt` of the line indexed by `miss_base`, then increment `cnt`.
  - The ack for word `WORDS-1` writes the tag, sets valid (unless a flush is pending), clears the flush-pending flag and returns to `IDLE`.
  - Throughout this state: `pc_stall` = 1, `instr` = NOP, and the `addr` input is ignored.
- **`mem_req` handshake:**
  - `mem_req` stays high for the whole of `REFILL` and is 0 in `IDLE`.
  - `mem_addr` is stable until acked and advances only on ack.
  - Back-to-back acks are legal: one word per cycle.
- **Flush:**
  - In `IDLE`, all valid bits clear at the next edge. A miss detected in the same cycle still starts its refill.
  - In `REFILL`, set flush-pending. The refill completes but the refilled line is left invalid. All other valid bits clear immediately.
- **Miss re-lookup:** after the refill, `IDLE` re-evaluates `addr`. It hits unless a flush occurred, in which case a new refill starts.
- **Reset (`rst` = 0, asynchronous):**
  - State `IDLE`, all valid bits 0, `cnt` 0, flush-pending 0, counters 0, `mem_req` 0, `mem_addr` 0.
  - Consequently `pc_stall` = 1 and `instr` = NOP (the lookup misses).
  - Reset during a refill abandons it and the line stays invalid.
  - Data and tag arrays are not reset.

## Timing
- Hit latency: combinational, the same cycle as `addr`.
- Miss detected in cycle T:
  - `mem_req` rises at T+1.
  - With zero-wait memory (ack held high), the last word is written at the edge ending T+WORDS, which is T+4 for the default `WORDS` = 4.
  - `pc_stall` is 0 in cycle T+WORDS+1 with the hit data.
- Minimum miss penalty is `WORDS+1` stall cycles. Each cycle `mem_ack` is low adds one cycle.
- The counters update at the edge ending each `IDLE` lookup cycle.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_count` increments on every `IDLE` cycle that hits.
  - `miss_count` increments once per `IDLE`→`REFILL` transition.
  - Both wrap modulo 2^32 and reset to 0.
- `ICACHE_PERF_EN` undefined: the ports still exist but are tied to 0, and no counter registers are built.

## Test plan
- **Reset then miss:** release reset with `addr` 0x00000100 and zero-wait memory. Require `pc_stall` = 1 and `instr` = 0x00000013 for 5 cycles, `mem_addr` 0x100, 0x104, 0x108, 0x10C in order, then `instr` = the word at 0x100 with `pc_stall` = 0.
- **Line hits:** after the fill above, step `addr` through 0x104, 0x108, 0x10C. Require hits with no stall and no `mem_req`.
- **Conflict eviction:** fetch 0x00000100 and then 0x00000200, which share index 0 with different tags. Require a second refill and then a miss again on 0x100, with `miss_count` = 3 when `ICACHE_PERF_EN` is defined.
- **Wait states:** hold `mem_ack` low for 3 cycles on each word. Require `mem_addr` stable during each wait and a total stall of 17 cycles.
- **Flush mid-refill:** pulse `flush` on the second refill word. Require the refill to complete, the line to stay invalid, and an immediate new refill of the same address.
- **Async reset mid-refill:** assert `rst` = 0 mid-edge-cycle. Require `mem_req` = 0 immediately and no valid lines, so the next fetch of the previous address misses.
